sakebi_eth_rx_parser: RTL and testbench

- Sits directly downstream of the RMII receiver, in the AXIS clock domain.
- Consumes the receiver's byte stream: post-SFD bytes, FCS still attached, no TLAST.
- Detects frame boundaries from idle gaps, captures the 14-byte Ethernet header and filters on destination MAC.
- Strips the 4-byte FCS and forwards the payload as an AXIS byte stream with TLAST.

---
 rtl/sakebi_eth_rx_parser.sv | 235 +++++++++++++++++++++++
 tb/tb_sakebi_eth_rx_parser.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sakebi_eth_rx_parser.sv
// Ethernet receive parser: frames the post-SFD byte stream on idle gaps, captures
// and filters the header, and forwards the payload with the 4-byte FCS removed.
module sakebi_eth_rx_parser #(
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned MAX_BYTES  = 1522
) (
  input  logic        i_axis_ACLK,
  input  logic        i_axis_ARESETn,
  input  logic        i_axis_TVALID,
  output logic        o_axis_TREADY,
  input  logic [7:0]  i_axis_TDATA,
  output logic        o_maxis_TVALID,
  input  logic        i_maxis_TREADY,
  output logic [7:0]  o_maxis_TDATA,
  output logic        o_maxis_TLAST,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_ethertype,
  output logic        o_hdr_valid,
  output logic        o_frame_drop,
  output logic        o_runt,
  output logic        o_oversize
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StClose,
    StDiscard
  } state_e;

  localparam logic [7:0]  GapLast  = 8'(GAP_CYCLES - 1);
  localparam logic [47:0] BcastMac = 48'hFFFF_FFFF_FFFF;
  // Smallest frame with at least one payload byte: 14 header + 1 + 4 FCS.
  localparam logic [10:0] MinBytes = 11'd19;

  state_e          state_q, state_d;
  logic [10:0]     bcnt_q, bcnt_d;
  logic [7:0]      gcnt_q, gcnt_d;
  logic [4:0][7:0] sr_q, sr_d;
  logic [2:0]      hcnt_q, hcnt_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [47:0]     dst_q, dst_d;
  logic [47:0]     src_q, src_d;
  logic [15:0]     type_q, type_d;
  logic            hdr_valid_q, hdr_valid_d;
  logic            drop_q, drop_d;
  logic            runt_q, runt_d;
  logic            oversize_q, oversize_d;

  logic full;
  logic out_free;
  logic accept;
  logic frame_end;
  logic dst_match;

  assign full      = (hcnt_q == 3'd5);
  assign out_free  = !out_valid_q || i_maxis_TREADY;
  assign accept    = i_axis_TVALID && o_axis_TREADY;
  assign frame_end = !i_axis_TVALID && (gcnt_q == GapLast);
  assign dst_match = (dst_q == LOCAL_MAC) || (dst_q == BcastMac);

  // Upstream ready: only the payload holdback and the close phase can apply backpressure.
  always_comb begin
    o_axis_TREADY = 1'b1;
    unique case (state_q)
      StPayload: o_axis_TREADY = !full || out_free;
      StClose:   o_axis_TREADY = 1'b0;
      default:   o_axis_TREADY = 1'b1;
    endcase
  end

  // Next-state, counters, header capture, holdback and output register.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    gcnt_d      = gcnt_q;
    sr_d        = sr_q;
    hcnt_d      = hcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    dst_d       = dst_q;
    src_d       = src_q;
    type_d      = type_q;
    hdr_valid_d = 1'b0;
    drop_d      = 1'b0;
    runt_d      = 1'b0;
    oversize_d  = 1'b0;

    if (out_valid_q && i_maxis_TREADY) begin
      out_valid_d = 1'b0;
    end

    // Gap counter saturates so a long idle period cannot wrap into a false frame end.
    if (accept) begin
      gcnt_d = 8'd0;
    end else if (!i_axis_TVALID && gcnt_q != 8'hFF) begin
      gcnt_d = gcnt_q + 8'd1;
    end

    if (accept) begin
      if (state_q == StIdle) begin
        bcnt_d = 11'd1;
      end else if (bcnt_q != 11'h7FF) begin
        bcnt_d = bcnt_q + 11'd1;
      end
    end

    // Header fields shift in MSB-first so the first byte lands in the top byte lane.
    if (accept && (state_q == StIdle || (state_q == StHdr && bcnt_q < 11'd6))) begin
      dst_d = {dst_q[39:0], i_axis_TDATA};
    end else if (accept && state_q == StHdr && bcnt_q < 11'd12) begin
      src_d = {src_q[39:0], i_axis_TDATA};
    end else if (accept && state_q == StHdr) begin
      type_d = {type_q[7:0], i_axis_TDATA};
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (accept && bcnt_q == 11'd13) begin
          if (dst_match) begin
            hdr_valid_d = 1'b1;
            state_d     = StPayload;
          end else begin
            drop_d  = 1'b1;
            state_d = StDiscard;
          end
        end else if (frame_end) begin
          runt_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StPayload: begin
        if (accept) begin
          sr_d = {sr_q[3:0], i_axis_TDATA};
          // Ready guarantees the output register is free whenever the holdback is full.
          if (full) begin
            out_valid_d = 1'b1;
            out_data_d  = sr_q[4];
            out_last_d  = 1'b0;
          end else begin
            hcnt_d = hcnt_q + 3'd1;
          end
        end else if (frame_end) begin
          if (bcnt_q >= MinBytes) begin
            state_d = StClose;
          end else begin
            runt_d  = 1'b1;
            hcnt_d  = 3'd0;
            state_d = StIdle;
          end
        end
      end
      StClose: begin
        // A valid TLAST byte in the output register marks the wait-for-acceptance phase.
        if (out_valid_q && out_last_q) begin
          if (i_maxis_TREADY) begin
            oversize_d = (32'(bcnt_q) > MAX_BYTES);
            state_d    = StIdle;
          end
        end else if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = sr_q[4];
          out_last_d  = 1'b1;
          hcnt_d      = 3'd0;
        end
      end
      StDiscard: begin
        if (frame_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_axis_ACLK) begin
    if (!i_axis_ARESETn) begin
      state_q     <= StIdle;
      bcnt_q      <= 11'd0;
      gcnt_q      <= 8'd0;
      sr_q        <= '0;
      hcnt_q      <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      dst_q       <= 48'd0;
      src_q       <= 48'd0;
      type_q      <= 16'd0;
      hdr_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      runt_q      <= 1'b0;
      oversize_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      gcnt_q      <= gcnt_d;
      sr_q        <= sr_d;
      hcnt_q      <= hcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      type_q      <= type_d;
      hdr_valid_q <= hdr_valid_d;
      drop_q      <= drop_d;
      runt_q      <= runt_d;
      oversize_q  <= oversize_d;
    end
  end

  assign o_maxis_TVALID = out_valid_q;
  assign o_maxis_TDATA  = out_data_q;
  assign o_maxis_TLAST  = out_last_q;
  assign o_dst_mac      = dst_q;
  assign o_src_mac      = src_q;
  assign o_ethertype    = type_q;
  assign o_hdr_valid    = hdr_valid_q;
  assign o_frame_drop   = drop_q;
  assign o_runt         = runt_q;
  assign o_oversize     = oversize_q;

endmodule

// File: tb/tb_sakebi_eth_rx_parser.sv
// Directed bench for sakebi_eth_rx_parser: a table of whole-frame vectors plus
// hand-written gap-boundary and mid-frame reset sequences.
module tb_sakebi_eth_rx_parser;

  localparam logic [47:0] LocalMac = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BcastMac = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OtherMac = 48'h02_00_00_00_00_02;
  localparam logic [47:0] SrcMac   = 48'h02_00_00_00_00_AA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        hdr_valid;
  logic        frame_drop;
  logic        runt;
  logic        oversize;

  bit bp_mode = 1'b0;

  always #5 clk = ~clk;

  sakebi_eth_rx_parser #(
    .LOCAL_MAC (LocalMac),
    .GAP_CYCLES(16),
    .MAX_BYTES (1522)
  ) dut (
    .i_axis_ACLK   (clk),
    .i_axis_ARESETn(rst_n),
    .i_axis_TVALID (s_tvalid),
    .o_axis_TREADY (s_tready),
    .i_axis_TDATA  (s_tdata),
    .o_maxis_TVALID(m_tvalid),
    .i_maxis_TREADY(m_tready),
    .o_maxis_TDATA (m_tdata),
    .o_maxis_TLAST (m_tlast),
    .o_dst_mac     (dst_mac),
    .o_src_mac     (src_mac),
    .o_ethertype   (ethertype),
    .o_hdr_valid   (hdr_valid),
    .o_frame_drop  (frame_drop),
    .o_runt        (runt),
    .o_oversize    (oversize)
  );

  // Downstream ready: constant 1, or toggling every cycle in backpressure mode.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_mode ? ~m_tready : 1'b1;
    end
  end

  // Monitor, sampled on the falling edge between input updates and the active edge.
  logic [7:0] got_data[$];
  bit         got_last[$];
  int n_hdr = 0, n_drop = 0, n_runt = 0, n_ovs = 0, n_last = 0;
  int stall_seen = 0, tready_viol = 0, hold_err = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
        hold_err <= hold_err + 1;
      prev_stall <= m_tvalid && !m_tready;
      prev_data  <= m_tdata;
      prev_last  <= m_tlast;
      if (m_tvalid && m_tready) begin
        got_data.push_back(m_tdata);
        got_last.push_back(m_tlast);
        if (m_tlast) n_last <= n_last + 1;
      end
      if (hdr_valid)  n_hdr  <= n_hdr + 1;
      if (frame_drop) n_drop <= n_drop + 1;
      if (runt)       n_runt <= n_runt + 1;
      if (oversize)   n_ovs  <= n_ovs + 1;
      if (s_tvalid && !s_tready) begin
        if (m_tvalid && !m_tready) stall_seen <= stall_seen + 1;
        else tready_viol <= tready_viol + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [47:0] dst, input int total,
                                            input int i);
    logic [111:0] hdr;
    int npay;
    hdr  = {dst, SrcMac, 16'h0800};
    npay = (total >= 18) ? total - 18 : 0;
    if (i < 14) return hdr[111 - 8*i -: 8];
    if (i < 14 + npay) return 8'(8'h11 + (i - 14));
    case (i - 14 - npay)
      0:       return 8'hDE;
      1:       return 8'hAD;
      2:       return 8'hBE;
      default: return 8'hEF;
    endcase
  endfunction

  // Starts and ends one time unit after an active edge.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w        = 0;
    s_tvalid = 1'b1;
    s_tdata  = b;
    @(negedge clk);
    while (!s_tready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("upstream_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [47:0] dst, input int total, input int gap_at,
                            input int gap_len);
    for (int i = 0; i < total; i++) begin
      if (i == gap_at) idle(gap_len);
      send_byte(frame_byte(dst, total, i));
    end
  endtask

  task automatic run_frame(input string tag, input logic [47:0] dst, input int total,
                           input int gap_at, input int gap_len, input int exp_out,
                           input int exp_hdr, input int exp_drop, input int exp_runt,
                           input int exp_ovs);
    int b_q, b_hdr, b_drop, b_runt, b_ovs, b_last, b_stall;
    int got, mism;
    b_q = got_data.size();
    b_hdr = n_hdr; b_drop = n_drop; b_runt = n_runt; b_ovs = n_ovs;
    b_last = n_last; b_stall = stall_seen;
    send_frame(dst, total, gap_at, gap_len);
    idle(16);
    idle(12);
    got  = got_data.size() - b_q;
    mism = 0;
    for (int i = 0; i < got; i++) begin
      if (got_data[b_q + i] !== 8'(8'h11 + i)) mism++;
    end
    check({tag, " out_count"}, got, exp_out);
    check({tag, " payload_bytes"}, mism, 0);
    check({tag, " tlast_count"}, n_last - b_last, (exp_out > 0) ? 1 : 0);
    if (got > 0) check({tag, " tlast_on_final"}, got_last[b_q + got - 1], 1);
    check({tag, " hdr_valid"}, n_hdr - b_hdr, exp_hdr);
    check({tag, " frame_drop"}, n_drop - b_drop, exp_drop);
    check({tag, " runt"}, n_runt - b_runt, exp_runt);
    check({tag, " oversize"}, n_ovs - b_ovs, exp_ovs);
    check({tag, " dst_mac"}, dst_mac, dst);
    if (total >= 14) begin
      check({tag, " src_mac"}, src_mac, SrcMac);
      check({tag, " ethertype"}, ethertype, 16'h0800);
    end
    if (bp_mode) check({tag, " upstream_stalled"}, (stall_seen - b_stall) > 0, 1);
  endtask

  typedef struct {
    logic [47:0] dst;
    int          total;
    bit          bp;
    int          exp_out;
    int          exp_hdr;
    int          exp_drop;
    int          exp_runt;
    int          exp_ovs;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_q, b_last, b_hdr, b_drop, b_runt, b_ovs;

    //          dst       total bp  out  hdr drop runt ovs
    vecs[0] = '{LocalMac, 28,   0,  10,  1,  0,   0,   0};
    vecs[1] = '{BcastMac, 28,   1,  10,  1,  0,   0,   0};
    vecs[2] = '{OtherMac, 30,   0,  0,   0,  1,   0,   0};
    vecs[3] = '{LocalMac, 28,   0,  10,  1,  0,   0,   0};
    vecs[4] = '{LocalMac, 10,   0,  0,   0,  0,   1,   0};
    vecs[5] = '{LocalMac, 18,   0,  0,   1,  0,   1,   0};
    vecs[6] = '{LocalMac, 19,   0,  1,   1,  0,   0,   0};
    vecs[7] = '{LocalMac, 1600, 0,  1582, 1, 0,   0,   1};
    vecs[8] = '{BcastMac, 1522, 0,  1504, 1, 0,   0,   0};
    vecs[9] = '{LocalMac, 1523, 0,  1505, 1, 0,   0,   1};

    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset upstream_ready", s_tready, 1);
    check("reset out_valid", m_tvalid, 0);
    check("reset out_last", m_tlast, 0);
    check("reset dst_mac", dst_mac, 0);
    check("reset ethertype", ethertype, 0);
    check("reset pulses", {hdr_valid, frame_drop, runt, oversize}, 0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 10; i++) begin
      bp_mode = vecs[i].bp;
      run_frame($sformatf("vec%0d", i), vecs[i].dst, vecs[i].total, -1, 0, vecs[i].exp_out,
                vecs[i].exp_hdr, vecs[i].exp_drop, vecs[i].exp_runt, vecs[i].exp_ovs);
      bp_mode = 1'b0;
    end

    // 15-cycle gap after five payload bytes keeps the frame open.
    run_frame("gap15", LocalMac, 28, 19, 15, 10, 1, 0, 0, 0);

    // Close timing: 15 idle cycles do not close, the 16th does.
    b_last = n_last;
    send_frame(LocalMac, 28, -1, 0);
    idle(15);
    check("gap close not_before_16", n_last - b_last, 0);
    check("gap close tlast_low", m_tlast, 0);
    idle(5);
    check("gap close after_16", n_last - b_last, 1);
    idle(10);

    // Reset after 20 bytes of an accepted frame.
    for (int i = 0; i < 20; i++) send_byte(frame_byte(LocalMac, 28, i));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset out_valid", m_tvalid, 0);
    check("midreset out_last", m_tlast, 0);
    check("midreset out_data", m_tdata, 0);
    check("midreset dst_mac", dst_mac, 0);
    check("midreset upstream_ready", s_tready, 1);
    b_q = got_data.size();
    b_last = n_last; b_hdr = n_hdr; b_drop = n_drop; b_runt = n_runt; b_ovs = n_ovs;
    idle(30);
    check("midreset no_output", got_data.size() - b_q, 0);
    check("midreset no_tlast", n_last - b_last, 0);
    check("midreset no_pulses", (n_hdr - b_hdr) + (n_drop - b_drop) + (n_runt - b_runt)
          + (n_ovs - b_ovs), 0);
    run_frame("post_reset", LocalMac, 28, -1, 0, 10, 1, 0, 0, 0);

    check("upstream_ready_only_when_stalled", tready_viol, 0);
    check("output_hold_while_stalled", hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
